// File: rtl/pio_pwm_ctrl.sv
// PWM generator fed by the PIO output word, with shadowed config applied at period boundaries.
// Optional complementary output with dead-time: define PWM_COMPL_EN.
module pio_pwm_ctrl #(
    parameter int DEAD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pio_in,
    output logic        pwm_out,
    output logic        pwm_n_out,
    output logic        period_tick,
    output logic        running,
    output logic        cfg_pending
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [10:0] pio_q;
    logic [10:0] act;
    logic [7:0]  cnt;
    logic [2:0]  pre;
    logic [2:0]  term;
    logic        tick;
    logic        boundary;
    logic        cmp;

    if (DEAD < 1 || DEAD > 15) begin : g_dead_check
        $error("DEAD out of range 1..15");
    end

    always_comb begin
        term = 3'd0;
        case (act[9:8])
            2'd0: term = 3'd0;
            2'd1: term = 3'd1;
            2'd2: term = 3'd3;
            2'd3: term = 3'd7;
            default: term = 3'd0;
        endcase
    end

    assign running  = (state == RUN);
    assign tick     = running && (pre == term);
    assign boundary = tick && (cnt == 8'hFF);
    assign cmp      = running && (cnt < act[7:0]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pio_q       <= '0;
            act         <= '0;
            cnt         <= '0;
            pre         <= '0;
            period_tick <= 1'b0;
            cfg_pending <= 1'b0;
        end else begin
            pio_q       <= pio_in;
            period_tick <= boundary;
            cfg_pending <= running && (pio_q != act);
            case (state)
                IDLE: begin
                    cnt <= '0;
                    pre <= '0;
                    if (pio_q[10]) begin
                        act   <= pio_q;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        pre <= '0;
                        cnt <= cnt + 8'd1;
                    end else begin
                        pre <= pre + 3'd1;
                    end
                    // New config only lands on the wrap, so no runt pulses.
                    if (boundary) begin
                        act <= pio_q;
                        if (!pio_q[10]) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PWM_COMPL_EN
    logic [1:0] tgt;
    logic [1:0] tgt_q;
    logic [1:0] drv;
    logic [3:0] dcnt;

    assign tgt = {cmp, running && !cmp};

    // Falling side drops at once; rising side waits DEAD cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            tgt_q <= '0;
            drv   <= '0;
            dcnt  <= '0;
        end else if (tgt != tgt_q) begin
            tgt_q <= tgt;
            dcnt  <= 4'(DEAD);
            drv   <= drv & tgt;
        end else if (dcnt > 4'd1) begin
            dcnt <= dcnt - 4'd1;
            drv  <= drv & tgt;
        end else begin
            dcnt <= '0;
            drv  <= tgt;
        end
    end

    assign pwm_out   = drv[1];
    assign pwm_n_out = drv[0];
`else
    always_ff @(posedge clk) begin
        if (reset) pwm_out <= 1'b0;
        else       pwm_out <= cmp;
    end

    assign pwm_n_out = 1'b0;
`endif

endmodule

// File: doc/pio_pwm_ctrl.md
# pio_pwm_ctrl

Downstream consumer of the 11-bit PIO output register: it takes the register's `out_port` word as a live configuration word and turns it into a glitch-free PWM waveform. Configuration changes are staged in a shadow register and applied only at a PWM period boundary, so software writes never produce runt pulses. The block sits between the PIO register and the board-level output pins.

## Interface

Parameters:
- `DEAD`, default 2: dead-time in clk cycles for the complementary output (used only when `PWM_COMPL_EN` is defined); legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic is on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `pio_in` input 11: configuration word, driven directly by the PIO `out_port`.
  - [10] = enable.
  - [9:8] = prescale select.
  - [7:0] = duty.
- `pwm_out` output 1: PWM output, registered.
- `pwm_n_out` output 1: complementary PWM output, registered (see Configuration).
- `period_tick` output 1: one-cycle pulse at each period boundary, registered.
- `running` output 1: high while the FSM is in RUN.
- `cfg_pending` output 1: high while a staged configuration differs from the active one.

## Operation

- `pio_q` samples `pio_in` every cycle. All decisions use `pio_q`, never `pio_in`.
- Prescaler:
  - 3-bit counter `pre`.
  - Prescale select 0/1/2/3 gives a tick every 1/2/4/8 clk cycles.
  - A tick occurs when `pre` equals the terminal value, and `pre` then returns to 0.
- Period counter:
  - 8-bit `cnt`, increments by 1 on each tick.
  - Wraps 255 -> 0, so one period is 256 ticks.
- Active configuration `act[10:0]` is loaded only at:
  - the IDLE -> RUN transition, or
  - a boundary, defined as the tick on which `cnt` wraps 255 -> 0. At a boundary, `act <= pio_q`.
- FSM:
  - **IDLE**:
    - `cnt = 0`, `pre = 0`, outputs low.
    - If `pio_q[10] = 1`: `act <= pio_q` and go to RUN.
  - **RUN**:
    - Counters run.
    - At a boundary, if `pio_q[10] = 0`: go to IDLE. The period already in progress always completes; disable never truncates it.
- Raw compare: `cmp = (state == RUN) && (cnt < act[7:0])`.
  - Duty 0 keeps the output low for the whole period.
  - Duty 255 keeps it high for 255 of every 256 ticks.
- `pwm_out` is registered from `cmp`.
- `cfg_pending = (state == RUN) && (pio_q != act)`, registered.
- A `pio_in` change in the same cycle as a boundary is not loaded at that boundary. It is seen at the next boundary.

## Timing

- Reset values: `pwm_out`, `pwm_n_out`, `period_tick`, `running`, `cfg_pending` = 0; `act`, `pio_q`, `cnt`, `pre` = 0; state = IDLE.
- Start latency, with `pio_in` carrying enable=1 sampled at edge E0:
  - E1: RUN, `running = 1`, `cnt = 0`.
  - E2: `pwm_out` reflects `cnt = 0` vs duty.
- `pwm_out` lags `cnt` by exactly one cycle throughout.
- `period_tick` is high for exactly one cycle following the boundary edge.
- Reset asserted mid-period: at the next edge all state returns to reset values and outputs drop to 0. No drain occurs.
- After reset deasserts, if `pio_in` enable is already set, RUN is entered two edges later.

## Configuration

- Macro `PWM_COMPL_EN`.
- Defined:
  - `pwm_n_out` is the complement of `cmp` with dead-time insertion.
  - On each `cmp` edge, the output going low drops on the same registered cycle.
  - The output going high is delayed by `DEAD` cycles.
  - `pwm_out` and `pwm_n_out` are never high in the same cycle.
  - Both outputs are low in IDLE.
- Not defined:
  - `pwm_n_out` is tied to 0.
  - `pwm_out` behaves as described in Operation with no dead-time.
  - `DEAD` is ignored.

## Test plan

- **Start and steady state.** Reset, then `pio_in = 0x440` (enable, prescale 0, duty 0x40).
  - `running = 1` two edges after `pio_in` is applied.
  - `pwm_out` high for 64 and low for 192 cycles per 256-cycle period.
  - `period_tick` pulses every 256 cycles.
- **Mid-period duty change.** While running with duty 0x40, write duty 0xC0 mid-period.
  - `cfg_pending = 1` until the next boundary.
  - The current period keeps 64 high cycles; the next period has 192.
- **Prescale select.** `pio_in = 0x710` (prescale 3, duty 0x10).
  - Period = 2048 clk cycles, high for 128 cycles.
- **Disable with drain.** Clear enable at `cnt = 10`.
  - The period completes.
  - `running` drops right after the boundary, with `pwm_out = 0`; no further `period_tick`.
- **Reset mid-operation and duty extremes.**
  - Assert `reset` at `cnt = 100`: all outputs are 0 on the next edge.
  - Duty 0 gives `pwm_out` constantly 0.
  - Duty 0xFF gives exactly 1 low cycle per period (prescale 0).
- **Complementary output** (with `PWM_COMPL_EN`, `DEAD = 2`).
  - `pwm_n_out` rises 2 cycles after `pwm_out` falls; `pwm_out` rises 2 cycles after `pwm_n_out` falls.
  - Overlap is never observed.
